// File: rtl/spi_frame_sequencer_if.sv
// Byte-stream input and committed RGBW output bundle of the SPI frame sequencer.
interface spi_frame_sequencer_if;
  logic       cs;
  logic       byte_rdy;
  logic [7:0] byte_data;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] white;
  logic       update;
  logic       frame_err;
  logic       busy;

  modport master (
    output cs, byte_rdy, byte_data,
    input  red, green, blue, white, update, frame_err, busy
  );

  modport slave (
    input  cs, byte_rdy, byte_data,
    output red, green, blue, white, update, frame_err, busy
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Parses SPI command frames into shadowed RGBW levels that are committed atomically.
// Defining SPI_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
module spi_frame_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [3:0]  HDR_SYNC       = 4'hA
) (
  input logic                  clk,
  input logic                  reset,
  spi_frame_sequencer_if.slave bus
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
`ifdef SPI_FRAME_CHECKSUM_EN
    CHECK   = 2'd2,
`endif
    DISCARD = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    mask_reg, mask_next;
  logic [3:0]    pending_reg, pending_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          update_reg, frame_err_reg;
  logic          commit, err_next;
  logic [3:0]    store_en;
  logic [3:0]    lowest;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]    xor_reg, xor_next;
`endif

  assign lowest      = pending_reg & (~pending_reg + 4'd1);
  assign cnt_inc     = cnt_reg + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      pending_reg   <= '0;
      cnt_reg       <= '0;
      update_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
      xor_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      pending_reg   <= pending_next;
      cnt_reg       <= cnt_next;
      update_reg    <= commit;
      frame_err_reg <= err_next;
`ifdef SPI_FRAME_CHECKSUM_EN
      xor_reg       <= xor_next;
`endif
    end
  end

  // cs deassertion outranks a coincident byte; a byte outranks a coincident timeout.
  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    pending_next = pending_reg;
    cnt_next     = '0;
    store_en     = '0;
    commit       = 1'b0;
    err_next     = 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
    xor_next     = xor_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!bus.cs && bus.byte_rdy) begin
          if (bus.byte_data[7:4] == HDR_SYNC && bus.byte_data[3:0] != 4'd0) begin
            state_next   = PAYLOAD;
            mask_next    = bus.byte_data[3:0];
            pending_next = bus.byte_data[3:0];
`ifdef SPI_FRAME_CHECKSUM_EN
            xor_next     = bus.byte_data;
`endif
          end else begin
            err_next   = 1'b1;
            state_next = DISCARD;
          end
        end
      end
      PAYLOAD: begin
        if (bus.cs) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (bus.byte_rdy) begin
          store_en     = lowest;
          pending_next = pending_reg & ~lowest;
`ifdef SPI_FRAME_CHECKSUM_EN
          xor_next     = xor_reg ^ bus.byte_data;
          if (pending_next == 4'd0) state_next = CHECK;
`else
          if (pending_next == 4'd0) begin
            commit     = 1'b1;
            state_next = IDLE;
          end
`endif
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = DISCARD;
        end else begin
          cnt_next = cnt_inc;
        end
      end
`ifdef SPI_FRAME_CHECKSUM_EN
      CHECK: begin
        if (bus.cs) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (bus.byte_rdy) begin
          state_next = IDLE;
          if (bus.byte_data == xor_reg) commit = 1'b1;
          else err_next = 1'b1;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = DISCARD;
        end else begin
          cnt_next = cnt_inc;
        end
      end
`endif
      DISCARD: begin
        if (bus.cs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final payload byte is committed straight from the bus, bypassing its shadow.
  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    logic [7:0] shadow_reg;
    logic [7:0] level_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (store_en[gi]) shadow_reg <= bus.byte_data;
        if (commit && mask_reg[gi]) level_reg <= store_en[gi] ? bus.byte_data : shadow_reg;
      end
    end
  end

  assign bus.red       = g_chan[0].level_reg;
  assign bus.green     = g_chan[1].level_reg;
  assign bus.blue      = g_chan[2].level_reg;
  assign bus.white     = g_chan[3].level_reg;
  assign bus.update    = update_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
Sits between the SPI byte receiver and the RGBW PWM channel registers. Consumes the receiver's one-cycle byte-ready pulses and parses them into command frames. Frame format: a header byte, payload bytes for the selected channels, and optionally a checksum byte. Payload is staged in shadow registers and committed atomically to the four channel outputs, so the PWM never sees a partially written colour.

Parameters:
TIMEOUT_CYCLES, 4096, clk cycles allowed between bytes inside a frame before abort; 0 disables timeout.
HDR_SYNC, 4'hA, required value of header bits [7:4].

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cs  input  1  SPI chip select, active low (frame boundary)
byte_rdy  input  1  one-cycle pulse: byte_data valid
byte_data  input  8  received byte
red  output  8  committed red level
green  output  8  committed green level
blue  output  8  committed blue level
white  output  8  committed white level
update  output  1  one-cycle pulse when channel outputs change
frame_err  output  1  one-cycle pulse on any aborted or rejected frame
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high. All state updates on posedge clk.
- Reset: red/green/blue/white = 8'h00, update = 0, frame_err = 0, busy = 0, state = IDLE, shadows and counters = 0.
- Header byte: [7:4] must equal HDR_SYNC; [3:0] = channel mask, bit0 = R, bit1 = G, bit2 = B, bit3 = W.
- States: IDLE, PAYLOAD, CHECK (only with the optional feature), DISCARD.
- IDLE, byte_rdy with valid sync and mask != 0:
  - latch mask; payload count = popcount(mask); go to PAYLOAD.
- IDLE, byte_rdy with bad sync or mask == 0:
  - frame_err pulse on the next cycle; go to DISCARD.
- PAYLOAD, byte_rdy:
  - store the byte in the shadow of the lowest pending set mask bit, then clear that pending bit. Order is always R, G, B, W, skipping unselected channels.
  - On the last payload byte, go to CHECK if enabled; otherwise commit.
- Commit:
  - selected channel outputs load their shadows; unselected channels hold their value.
  - update = 1 for exactly one cycle, in the cycle after the byte_rdy of the final byte. Latency 1.
  - Return to IDLE. Back-to-back frames within one cs assertion are legal.
- DISCARD: ignore all bytes until cs = 1, then go to IDLE.
- cs = 1 (deasserted):
  - from PAYLOAD or CHECK: abort; frame_err pulse next cycle; shadows discarded; outputs unchanged; go to IDLE.
  - from IDLE or DISCARD: go to IDLE, no error.
- Simultaneous cs = 1 and byte_rdy: cs wins and the byte is dropped. If the state was PAYLOAD or CHECK, this is an abort even if it was the final byte.
- Timeout:
  - counter clears on each byte_rdy and runs only in PAYLOAD or CHECK.
  - when it reaches TIMEOUT_CYCLES: frame_err pulse, go to DISCARD.
  - counter width is $clog2(TIMEOUT_CYCLES + 1); no wrap.
- update and frame_err are never high in the same cycle.
- byte_rdy pulses are assumed at least 2 cycles apart; no input FIFO.
- Reset mid-frame: immediate return to reset values. No update or frame_err pulse.

Optional Feature:
Macro SPI_FRAME_CHECKSUM_EN.
- Defined: after the payload, one extra byte is required, equal to the XOR of the header and all payload bytes.
  - Match: commit with update 1 cycle after the checksum byte_rdy.
  - Mismatch: frame_err pulse, outputs unchanged, go to IDLE.
  - The CHECK state and the XOR accumulator exist only in this build.
- Undefined: no CHECK state; commit directly after the last payload byte.

Test Plan:
- Reset; cs = 0; bytes AF,11,22,33,44 -> 1 cycle after the last byte_rdy: red = 11, green = 22, blue = 33, white = 44, update pulse of width 1; busy low afterwards.
- From that state, bytes A5,80,90 -> red = 80, blue = 90, green = 22 and white = 44 unchanged; one update pulse.
- Bytes A3,55 then cs = 1 -> frame_err pulse of one cycle, no update, outputs unchanged, state IDLE; next frame A1,07 -> red = 07.
- Header 5F then 01,02 with cs held low -> one frame_err, payload ignored; after cs toggles high then low, A8,FF -> white = FF.
- TIMEOUT_CYCLES = 16; A1 then no byte for 16 cycles -> frame_err at timeout, DISCARD; a later 01 is ignored until cs cycles.
- With SPI_FRAME_CHECKSUM_EN: A1,10,B1 -> red = 10, update; A1,10,00 -> frame_err, red stays 10.
